// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared widths, FSM encodings and helpers for the divider controller
package div_ctrl_pkg;

  localparam int DATALENGTH      = 32;
  localparam int DIV_RESULT_SIZE = 2 * DATALENGTH;
  localparam int WORK_SIZE       = 2 * DATALENGTH + 1;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } divState_t;

  // Two's complement negate when requested; used both for operand magnitude and sign correction.
  function automatic logic [DATALENGTH-1:0] negIf(input logic neg, input logic [DATALENGTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration on the 65-bit working register
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [WORK_SIZE-1:0]  workIn,
  input  logic [DATALENGTH-1:0] divisor,
  output logic [WORK_SIZE-1:0]  workOut
);

  logic [WORK_SIZE:0]    shifted;
  logic [DATALENGTH+1:0] diff;

  // Partial remainder stays below the divisor, so the top shifted bit is always zero and diff MSB is the borrow.
  always_comb begin
    shifted = {workIn, 1'b0};
    diff    = shifted[WORK_SIZE:DATALENGTH] - {2'b00, divisor};
    if (!diff[DATALENGTH+1]) begin
      workOut = {diff[DATALENGTH:0], shifted[DATALENGTH-1:1], 1'b1};
    end else begin
      workOut = shifted[WORK_SIZE-1:0];
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle DIV/DIVU controller: FSM, iteration counter, sign correction, result register
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       div_start,
  input  logic                       div_signed,
  input  logic [DATALENGTH-1:0]      opdata1,
  input  logic [DATALENGTH-1:0]      opdata2,
  input  logic                       annul,
  output logic [DIV_RESULT_SIZE-1:0] result,
  output logic                       ready,
  output logic                       stall_req
);

  divState_t             state, nextState;
  logic [4:0]            cnt;
  logic [WORK_SIZE-1:0]  workReg, stepOut;
  logic [DATALENGTH-1:0] divisor;
  logic                  quoNeg, remNeg;
  logic                  readyQ;
  logic                  accept;

  assign accept = (div_start == DIV_START) && !annul;

  div_step uStep (
    .workIn  (workReg),
    .divisor (divisor),
    .workOut (stepOut)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= DIV_FREE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (annul) begin
      nextState = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE: begin
          if (accept) begin
            nextState = (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
          end
        end
        DIV_BYZERO: nextState = DIV_END;
        DIV_ON: begin
          if (cnt == 5'd31) begin
            nextState = DIV_END;
          end
        end
        DIV_END:  nextState = DIV_FREE;
        default:  nextState = DIV_FREE;
      endcase
    end
  end

  always_comb begin
    stall_req = 1'b0;
    if (!annul) begin
      case (state)
        DIV_ON, DIV_BYZERO: stall_req = 1'b1;
        DIV_FREE:           stall_req = (div_start == DIV_START);
        default:            stall_req = 1'b0;
      endcase
    end
  end

  // Result and ready are loaded on the edge into END so both are visible during the END cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      workReg <= '0;
      divisor <= '0;
      quoNeg  <= 1'b0;
      remNeg  <= 1'b0;
      result  <= '0;
      readyQ  <= 1'b0;
    end else begin
      readyQ <= (nextState == DIV_END);
      case (state)
        DIV_FREE: begin
          if (accept) begin
            cnt     <= '0;
            workReg <= {{(DATALENGTH+1){1'b0}}, negIf(div_signed & opdata1[DATALENGTH-1], opdata1)};
            divisor <= negIf(div_signed & opdata2[DATALENGTH-1], opdata2);
            quoNeg  <= div_signed & (opdata1[DATALENGTH-1] ^ opdata2[DATALENGTH-1]);
            remNeg  <= div_signed & opdata1[DATALENGTH-1];
          end
        end
        DIV_ON: begin
          workReg <= stepOut;
          cnt     <= cnt + 5'd1;
          if (nextState == DIV_END) begin
            result <= {negIf(remNeg, stepOut[2*DATALENGTH-1:DATALENGTH]),
                       negIf(quoNeg, stepOut[DATALENGTH-1:0])};
          end
        end
        DIV_BYZERO: begin
          if (nextState == DIV_END) begin
            result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = readyQ & ~annul;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with directed divide vectors
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  div_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          when;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monE;
  int          nCmp = 0;
  int          nBad = 0;
  int          lastReadyCyc = -1;
  logic [63:0] lastRes = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s @cycle %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && ready) begin
      if (sbq.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL unexpected_ready @cycle %0d: ready=1 required 0", cyc);
      end else begin
        monE = sbq.pop_front();
        chk("result", result, monE.res);
        chk("ready_cycle", 64'(cyc), 64'(monE.when));
      end
      lastReadyCyc = cyc;
    end
  end

  // Call #1 after a posedge; returns #1 after the posedge following the ready cycle.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int   t;
    int   lat;
    exp_t e;
    lat        = (b == 32'd0) ? 2 : 33;
    div_signed = s;
    opdata1    = a;
    opdata2    = b;
    div_start  = 1'b1;
    t          = cyc;
    e.res      = exp;
    e.when     = t + lat;
    sbq.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clock);
      chk("stall_req", 64'(stall_req), (k < lat) ? 64'd1 : 64'd0);
      @(posedge clock);
      #1;
      if (k == 0) begin
        div_start = 1'b0;
        opdata1   = 32'hDEADBEEF;
        opdata2   = 32'h00000001;
      end
    end
    if (sbq.size() != 0) begin
      nCmp++;
      nBad++;
      $display("FAIL missing_ready: %0d pending results required 0", sbq.size());
      sbq.delete();
    end
    lastRes = exp;
  endtask

  initial begin
    int firstReady;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_state", 64'(dut.state), 64'(DIV_FREE));
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    @(posedge clock);
    #1;

    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    issue(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
    issue(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14});
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    issue(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
    issue(1'b0, 32'd1234, 32'd0, 64'd0);
    issue(1'b0, 32'd5, 32'd3, {32'd2, 32'd1});
    issue(1'b1, 32'hFFFFFFFB, 32'd0, 64'd0);
    issue(1'b0, 32'hFFFFFFFF, 32'h00010000, {32'h0000FFFF, 32'h0000FFFF});

    // Annul mid-division: no ready, result keeps its previous value.
    div_signed = 1'b0;
    opdata1    = 32'd50;
    opdata2    = 32'd5;
    div_start  = 1'b1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    annul = 1'b1;
    @(negedge clock);
    chk("annul_stall", 64'(stall_req), 64'd0);
    @(posedge clock);
    #1;
    annul = 1'b0;
    @(negedge clock);
    chk("annul_state", 64'(dut.state), 64'(DIV_FREE));
    chk("annul_result", result, lastRes);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk("post_annul_stall", 64'(stall_req), 64'd0);
    end
    chk("annul_result_held", result, lastRes);
    @(posedge clock);
    #1;

    // Reset in the middle of a division, then back-to-back divides.
    div_signed = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    div_start  = 1'b1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_state", 64'(dut.state), 64'(DIV_FREE));
    chk("midreset_result", result, 64'd0);
    chk("midreset_ready", 64'(ready), 64'd0);
    @(posedge clock);
    #1;
    issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    firstReady = lastReadyCyc;
    issue(1'b0, 32'd10, 32'd4, {32'd2, 32'd2});
    chk("b2b_ready_gap", 64'(lastReadyCyc - firstReady), 64'd34);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle controller for the shared 32-bit integer divider used by DIV/DIVU in the EX stage. It accepts a request from EX and stalls the pipeline while the divider runs. It sequences 32 restoring-division iterations, applies signed/unsigned correction, and returns a 64-bit {remainder, quotient} result for the HI/LO write. Exception flushes abort it.

## Interface
- No parameters; width constants come from `defines.vh` (`DATALENGTH` = 32 bits).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `div_start`  in  1  EX holds a valid DIV/DIVU this cycle.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1`  in  32  dividend (rs).
- `opdata2`  in  32  divisor (rt).
- `annul`  in  1  flush from exception/ERET; cancels any division in progress.
- `result`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}; registered.
- `ready`  out  1  one-cycle pulse: `result` is valid.
- `stall_req`  out  1  request to the stall unit to freeze IF/ID/EX.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset: IDLE, `result`=0, `ready`=0, iteration count=0.
- IDLE:
  - If `div_start` & ~`annul` and `opdata2`==0, go to DIVZERO.
  - If `div_start` & ~`annul` and `opdata2`!=0, latch operands and go to ON.
  - Signed mode latches absolute values of both operands.
  - Also latches two sign flags: quotient negate = sign(op1)^sign(op2); remainder negate = sign(op1).
- ON: one restoring step per cycle on a 65-bit {partial remainder, dividend} register.
  - Each step does a 33-bit trial subtract of the divisor.
  - If the subtract does not borrow, shift in quotient bit 1; otherwise shift in 0 and restore.
  - Count 0..31; after step 31, go to END.
- DIVZERO: one cycle, result forced to 64'h0, then END. The architectural result is undefined; this block defines it as 0.
- END:
  - Apply the negations.
  - Register `result` and assert `ready` for exactly this cycle.
  - Go unconditionally to IDLE.
  - `div_start` seen in END is ignored. The next request is accepted from IDLE.
- `annul` in any state: next state IDLE, `ready`=0, `result` unchanged, pending work discarded.
- `result` holds its value until the next END.
- Overflow case 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0. This falls out of unsigned magnitude arithmetic, so no special path.
- `stall_req` is combinational:
  - 1 in ON and DIVZERO;
  - 1 in IDLE when `div_start` & ~`annul`;
  - 0 in END and whenever `annul`=1.

## Timing
- Request accepted at IDLE cycle T. ON covers T+1..T+32. END at T+33, with `ready`=1 and `result` valid at T+33.
- Divide-by-zero: DIVZERO at T+1, `ready` at T+2.
- `stall_req` falls in the `ready` cycle, so EX retires the divide and the next instruction enters EX at T+34.
- Back-to-back divides: the second `div_start` is first seen in IDLE at T+34, then proceeds as above.
- Operands are sampled only at acceptance. Changes to `opdata1`/`opdata2` during ON have no effect.
- `reset` has priority over `annul`, which has priority over all other transitions.

## Structure
- `defines.vh` gains:
  - state encodings `DIV_FREE`, `DIV_BYZERO`, `DIV_ON`, `DIV_END` (2 bits);
  - `DIV_RESULT_SIZE` (63:0);
  - constants `DIV_START`/`DIV_STOP`.
- One natural sub-module: `div_step`. It is combinational.
  - Inputs: 65-bit working register and 32-bit divisor.
  - Operation: 33-bit trial subtract, restore and shift.
  - Output: next 65-bit working register.
- `div_ctrl` holds the FSM, counter, sign flags, correction and output registers.

## Test plan
- DIVU 100 / 7: `ready` 33 cycles after acceptance; `result`={32'd2, 32'd14}; `stall_req` high for cycles T..T+32, low at T+33.
- DIV -7 / 2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 gives quotient -3, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Divide by zero (any dividend): `ready` at T+2, `result`=64'h0, `stall_req` high for T..T+1.
- `annul` at T+10 during ON: state IDLE at T+11; no `ready` pulse; `result` keeps its previous value; `stall_req` 0 from T+10.
- `reset` at T+5, then back-to-back DIVU 9/3 and 10/4:
  - state IDLE, `result`=0 and `ready`=0 after the reset edge;
  - results {0,3} then {2,2};
  - second `ready` exactly 34 cycles after the first.
